// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped 32-bit bidirectional I/O port.
//
// Each pin has an enable, a direction bit, an output latch, a debounced input
// path and a sticky rising-edge interrupt status bit.
//
// Ports:
//   sys_clk   - system clock, all state changes on the rising edge
//   rst_sync  - synchronous active-high reset
//   ce        - chip enable from the address decoder
//   wr        - 1 = write, 0 = read (qualified by ce)
//   addr      - register word index
//   data_in   - write data
//   data_out  - combinational read data, 0 when ce = 0
//   irq       - interrupt request, OR of IRQ_ST & IRQ_EN
//   port_io   - pins, driven only when enabled as outputs
//
// Register map (addr): 0 DATA, 1 CFG (1 = input), 2 EN, 3 IRQ_EN,
//   4 IRQ_ST (write-1-to-clear), 5 DEB_DIV [15:0], 6/7 reserved (read 0).
module io_port_ctrl #(
  parameter logic [15:0] DEB_DIV_RST = 16'd0
) (
  input  logic        sys_clk,
  input  logic        rst_sync,
  input  logic        ce,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq,
  inout  wire  [31:0] port_io
);

  localparam logic [2:0] AddrData  = 3'd0;
  localparam logic [2:0] AddrCfg   = 3'd1;
  localparam logic [2:0] AddrEn    = 3'd2;
  localparam logic [2:0] AddrIrqEn = 3'd3;
  localparam logic [2:0] AddrIrqSt = 3'd4;
  localparam logic [2:0] AddrDiv   = 3'd5;

  // Bus-visible registers
  logic [31:0] r_data;
  logic [31:0] r_cfg;
  logic [31:0] r_en;
  logic [31:0] r_irq_en;
  logic [31:0] r_irq_st;
  logic [15:0] r_deb_div;

  // Input path
  logic [15:0] r_cnt;
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_hist0;  // newest tick sample
  logic [31:0] r_hist1;
  logic [31:0] r_hist2;  // oldest tick sample
  logic [31:0] r_deb;
  logic [31:0] r_deb_prev;

  logic        w_wr;
  logic        w_tick;
  logic [31:0] w_all_ones;
  logic [31:0] w_all_zeros;
  logic [31:0] w_deb_next;
  logic [31:0] w_set;
  logic [31:0] w_w1c;
  logic [31:0] w_drive;
  logic [31:0] w_data_rd;

  assign w_wr   = ce & wr;
  assign w_tick = (r_cnt == 16'd0);

  // Agreement is judged on the history as it will be after this tick, so the
  // debounced value moves on the same edge that completes the third sample.
  assign w_all_ones  = r_sync2 & r_hist0 & r_hist1;
  assign w_all_zeros = ~(r_sync2 | r_hist0 | r_hist1);
  assign w_deb_next  = (r_deb | w_all_ones) & ~w_all_zeros;

  assign w_set = r_deb & ~r_deb_prev & r_en & r_cfg;
  assign w_w1c = (w_wr && (addr == AddrIrqSt)) ? data_in : 32'd0;

  // Reset releases the pins and the irq line immediately, not one edge later.
  assign w_drive = rst_sync ? 32'd0 : (r_en & ~r_cfg);
  assign irq     = ~rst_sync & |(r_irq_st & r_irq_en);

  for (genvar gi = 0; gi < 32; gi++) begin : g_pin
    assign port_io[gi] = w_drive[gi] ? r_data[gi] : 1'bz;
  end

  assign w_data_rd = (r_en & r_cfg & r_deb) | (r_en & ~r_cfg & r_data);

  always_comb begin
    data_out = 32'd0;
    if (ce) begin
      case (addr)
        AddrData:  data_out = w_data_rd;
        AddrCfg:   data_out = r_cfg;
        AddrEn:    data_out = r_en;
        AddrIrqEn: data_out = r_irq_en;
        AddrIrqSt: data_out = r_irq_st;
        AddrDiv:   data_out = {16'd0, r_deb_div};
        default:   data_out = 32'd0;
      endcase
    end
  end

  // Bus registers; a new edge beats a same-cycle write-1-to-clear.
  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      r_data    <= 32'd0;
      r_cfg     <= 32'hFFFF_FFFF;
      r_en      <= 32'd0;
      r_irq_en  <= 32'd0;
      r_irq_st  <= 32'd0;
      r_deb_div <= DEB_DIV_RST;
    end else begin
      r_irq_st <= (r_irq_st & ~w_w1c) | w_set;
      if (w_wr) begin
        case (addr)
          AddrData:  r_data    <= data_in;
          AddrCfg:   r_cfg     <= data_in;
          AddrEn:    r_en      <= data_in;
          AddrIrqEn: r_irq_en  <= data_in;
          AddrDiv:   r_deb_div <= data_in[15:0];
          default:   ;
        endcase
      end
    end
  end

  // Debounce prescaler; a DEB_DIV write restarts the count at once.
  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      r_cnt <= DEB_DIV_RST;
    end else if (w_wr && (addr == AddrDiv)) begin
      r_cnt <= data_in[15:0];
    end else if (w_tick) begin
      r_cnt <= r_deb_div;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Synchronizer, tick-sampled history and debounced value. These track the
  // pins regardless of enable or direction.
  always_ff @(posedge sys_clk) begin
    if (rst_sync) begin
      r_sync1    <= 32'd0;
      r_sync2    <= 32'd0;
      r_hist0    <= 32'd0;
      r_hist1    <= 32'd0;
      r_hist2    <= 32'd0;
      r_deb      <= 32'd0;
      r_deb_prev <= 32'd0;
    end else begin
      r_sync1    <= port_io;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      if (w_tick) begin
        r_hist0 <= r_sync2;
        r_hist1 <= r_hist0;
        r_hist2 <= r_hist1;
        r_deb   <= w_deb_next;
      end
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios followed by random
// bus traffic and pin activity, all compared against a behavioural model.
module tb_io_port_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic        ce = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        irq;
  wire  [31:0] port_io;

  logic [31:0] tb_oe  = 32'd0;
  logic [31:0] tb_drv = 32'd0;
  logic        tb_float = 1'b1;  // 1: bench drives no pin at all
  logic [31:0] pin_want = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  always #10 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 32; g++) begin : g_tb_pin
    assign port_io[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
  end

  io_port_ctrl dut (
    .sys_clk  (sys_clk),
    .rst_sync (rst_sync),
    .ce       (ce),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq),
    .port_io  (port_io)
  );

  // Behavioural model state
  logic [31:0] m_data, m_cfg, m_en, m_ien, m_st, m_deb, m_debp;
  logic [15:0] m_div;
  int          m_phase;          // cycles since the prescaler was last reloaded
  logic [31:0] m_pin_q[$];       // pin samples still in the synchronizer
  logic [31:0] m_tick_q[$];      // last three tick samples, oldest first
  logic [31:0] m_pin;            // resolved pin value this cycle
  logic        m_in_rst, m_in_ce, m_in_wr;
  logic [2:0]  m_in_addr;
  logic [31:0] m_in_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] pin_val();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = (port_io[i] === 1'b1);
    return v;
  endfunction

  task automatic model_reset();
    m_data = '0; m_cfg = '1; m_en = '0; m_ien = '0; m_st = '0;
    m_deb = '0; m_debp = '0; m_div = 16'd0; m_phase = 0;
    m_pin_q  = '{32'd0, 32'd0};
    m_tick_q = '{32'd0, 32'd0, 32'd0};
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0:    return (m_en & m_cfg & m_deb) | (m_en & ~m_cfg & m_data);
      3'd1:    return m_cfg;
      3'd2:    return m_en;
      3'd3:    return m_ien;
      3'd4:    return m_st;
      3'd5:    return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] set_v, w1c, nd;
    logic        tick;
    if (m_in_rst) begin
      model_reset();
      return;
    end
    tick  = (m_phase % (int'(m_div) + 1)) == int'(m_div);
    set_v = m_deb & ~m_debp & m_en & m_cfg;
    nd    = m_deb;
    if (tick) begin
      m_tick_q.push_back(m_pin_q[0]);
      void'(m_tick_q.pop_front());
      for (int i = 0; i < 32; i++) begin
        if (m_tick_q[0][i] == m_tick_q[1][i] && m_tick_q[1][i] == m_tick_q[2][i])
          nd[i] = m_tick_q[2][i];
      end
    end
    m_debp = m_deb;
    m_deb  = nd;
    m_pin_q.push_back(m_pin);
    void'(m_pin_q.pop_front());
    w1c  = (m_in_ce && m_in_wr && m_in_addr == 3'd4) ? m_in_din : 32'd0;
    m_st = (m_st & ~w1c) | set_v;
    m_phase++;
    if (m_in_ce && m_in_wr) begin
      case (m_in_addr)
        3'd0: m_data = m_in_din;
        3'd1: m_cfg  = m_in_din;
        3'd2: m_en   = m_in_din;
        3'd3: m_ien  = m_in_din;
        3'd5: begin m_div = m_in_din[15:0]; m_phase = 0; end
        default: ;
      endcase
    end
  endtask

  // Apply one bus cycle at the falling edge and check combinational outputs.
  // Pins that change owner at the next edge are driven by the bench with the
  // same value the DUT drives, so no pin ever sees two different drivers.
  task automatic drive(input logic r, input logic c, input logic w, input logic [2:0] a,
                       input logic [31:0] d);
    logic [31:0] cur, nxt, n_data, n_en, n_cfg;
    @(negedge sys_clk);
    rst_sync = r; ce = c; wr = w; addr = a; data_in = d;
    m_in_rst = r; m_in_ce = c; m_in_wr = w; m_in_addr = a; m_in_din = d;
    n_data = m_data; n_en = m_en; n_cfg = m_cfg;
    if (c && w) begin
      if (a == 3'd0) n_data = d;
      if (a == 3'd1) n_cfg = d;
      if (a == 3'd2) n_en = d;
    end
    cur = r ? 32'd0 : (m_en & ~m_cfg);
    nxt = r ? 32'd0 : (n_en & ~n_cfg);
    if (tb_float) begin
      tb_oe  = 32'd0;
      tb_drv = 32'd0;
    end else begin
      tb_oe  = ~(cur & nxt);
      tb_drv = (pin_want & ~(cur ^ nxt)) | (m_data & cur & ~nxt) | (n_data & ~cur & nxt);
    end
    m_pin = (cur & m_data) | (~cur & tb_oe & tb_drv);
    #1;
    check("data_out", data_out, c ? exp_read(a) : 32'd0);
    check("irq", {31'd0, irq}, {31'd0, ~r & |(m_st & m_ien)});
    check("pins", pin_val(), m_pin);
  endtask

  task automatic clk_edge();
    @(posedge sys_clk);
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
      clk_edge();
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b1, a, d);
    clk_edge();
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp_d,
                    input logic exp_irq);
    drive(1'b0, 1'b1, 1'b0, a, $urandom());
    check(tag, data_out, exp_d);
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    clk_edge();
  endtask

  initial begin
    logic [31:0] rst_exp [8];
    logic        r, c, w;
    logic [2:0]  a;
    logic [31:0] d;
    rst_exp = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    model_reset();

    // Reset: three cycles, then every register
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
      clk_edge();
    end
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      rd("rst_reg", a, rst_exp[i], 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("rst_pins_z", pin_val(), 32'd0);
    clk_edge();

    // Output drive with the low nibble left as undriven inputs
    wr_reg(3'd2, 32'hFFFF_FFF0);
    wr_reg(3'd1, 32'h0000_000F);
    wr_reg(3'd0, 32'hA5A5_A5A0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("out_pins", pin_val(), 32'hA5A5_A5A0);
    clk_edge();
    rd("out_data", 3'd0, 32'hA5A5_A5A0, 1'b0);

    // Button press on pin 3 with DEB_DIV = 0
    tb_float = 1'b0;
    pin_want = 32'd0;
    wr_reg(3'd2, 32'h0000_000F);
    wr_reg(3'd1, 32'hFFFF_FFFF);
    wr_reg(3'd3, 32'h0000_0008);
    wr_reg(3'd5, 32'd0);
    idle(10);
    rd("btn_idle", 3'd4, 32'd0, 1'b0);
    pin_want[3] = 1'b1;
    idle(5);
    pin_want[3] = 1'b0;
    rd("btn_edge5", 3'd4, 32'd0, 1'b0);
    rd("btn_edge6", 3'd4, 32'h8, 1'b1);
    wr_reg(3'd4, 32'h8);
    rd("btn_clr", 3'd4, 32'd0, 1'b0);

    // Glitch: 10-cycle pulse on pin 2 spanning only two ticks of DEB_DIV = 3
    wr_reg(3'd5, 32'd3);
    idle(2);
    pin_want[2] = 1'b1;
    idle(10);
    pin_want[2] = 1'b0;
    idle(30);
    rd("glitch_data", 3'd0, 32'd0, 1'b0);
    rd("glitch_st", 3'd4, 32'd0, 1'b0);

    // Masking: edges are recorded even with IRQ_EN = 0
    wr_reg(3'd5, 32'd0);
    wr_reg(3'd3, 32'd0);
    pin_want[1] = 1'b1; idle(8);
    pin_want[1] = 1'b0; idle(8);
    pin_want[0] = 1'b1; idle(8);
    pin_want[0] = 1'b0; idle(8);
    rd("mask_st", 3'd4, 32'h3, 1'b0);
    wr_reg(3'd3, 32'h1);
    rd("mask_irq", 3'd4, 32'h3, 1'b1);

    // Set and clear of IRQ_ST[0] on the same edge: set wins
    wr_reg(3'd4, 32'h3);
    idle(8);
    pin_want[0] = 1'b1;
    idle(5);
    wr_reg(3'd4, 32'h1);
    rd("collide_st", 3'd4, 32'h1, 1'b1);
    pin_want[0] = 1'b0;

    // Reset in the middle of output drive
    tb_float = 1'b1;
    wr_reg(3'd2, 32'hFFFF_FFFF);
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd0, 32'hA5A5_A5A5);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("drv_pins", pin_val(), 32'hA5A5_A5A5);
    check("drv_irq", {31'd0, irq}, 32'd1);
    clk_edge();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    check("rst_mid_pins", pin_val(), 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    clk_edge();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("post_rst_pins", pin_val(), 32'd0);
    clk_edge();
    rd("post_rst_st", 3'd4, 32'd0, 1'b0);
    rd("post_rst_cfg", 3'd1, 32'hFFFF_FFFF, 1'b0);

    // Random traffic against the model
    tb_float = 1'b0;
    pin_want = 32'd0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 3'($urandom_range(0, 7));
        pin_want[a] = ~pin_want[a];
      end
      r = ($urandom_range(0, 299) == 0);
      c = 1'($urandom_range(0, 1));
      w = c && ($urandom_range(0, 2) == 0);
      a = 3'($urandom_range(0, 7));
      d = $urandom();
      if (a == 3'd5) d = {d[31:16], 14'd0, d[1:0]};
      drive(r, c, w, a, d);
      clk_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Memory-mapped 32-bit bidirectional I/O port peripheral for the MIPS microcontroller; it is the on-chip end of the `port_io` pins that the board, or the bench, drives with push-buttons and reads as outputs. Each pin has its own enable, direction, output latch, debounced input and rising-edge interrupt. The block sits on the processor's data bus behind the address decoder and drives a single interrupt request line to the core.

## Interface
- `DEB_DIV_RST`, 16'd0: reset value of the debounce prescaler reload (0 = sample every cycle).
- `sys_clk` in 1: system clock; all state changes on the rising edge.
- `rst_sync` in 1: synchronous, active-high reset.
- `ce` in 1: chip enable from the address decoder.
- `wr` in 1: 1 = write and 0 = read, qualified by `ce`.
- `addr` in 3: register word index.
- `data_in` in 32: write data.
- `data_out` out 32: read data, combinational from `addr`; 0 when `ce` = 0.
- `irq` out 1: interrupt request, combinational OR of `IRQ_ST & IRQ_EN`.
- `port_io` inout 32: pins; bit i is driven only when `EN[i]` = 1 and `CFG[i]` = 0, otherwise high-Z.

## Operation
- Registers (`addr`), with reset values:
  - 0 `DATA`: write loads the output latch. Read returns per bit: debounced input if input, output latch if output, 0 if disabled. Latch resets to 0.
  - 1 `CFG`: 1 = input, 0 = output. Resets to all ones.
  - 2 `EN`: per-pin enable. Resets to 0, so all pins are high-Z.
  - 3 `IRQ_EN`: per-pin interrupt mask. Resets to 0.
  - 4 `IRQ_ST`: sticky status. Writing 1 clears a bit (write-1-to-clear). Resets to 0.
  - 5 `DEB_DIV`: bits [15:0], prescaler reload; upper bits read 0. Resets to `DEB_DIV_RST`.
  - 6, 7: reads return 0, writes are ignored.
- Input path, per pin:
  - Two-flop synchronizer on `port_io[i]`.
  - A shared prescaler counts down from `DEB_DIV` and produces a one-cycle `tick` when it reaches 0, then reloads. With `DEB_DIV` = 0, `tick` is asserted every cycle. Writing `DEB_DIV` reloads the counter immediately.
  - On each `tick`, the synchronized bit shifts into a 3-bit history register. The debounced value updates only when all 3 history bits agree; otherwise it holds.
  - Synchronizer, history and debounced value reset to 0.
- Edge detect:
  - `rise[i]` = debounced[i] & ~debounced_prev[i].
  - It sets `IRQ_ST[i]` only when `EN[i]` & `CFG[i]`.
  - `IRQ_EN` gates only `irq`. `IRQ_ST` records edges regardless of the mask.
- Simultaneous set and W1C on the same bit in the same cycle: the set wins, and the bit reads 1 afterwards.
- Disabling a pin or switching it to output does not clear its `IRQ_ST` bit. The history and debounced value keep tracking the pin, but no new edges are recorded.
- `rst_sync` asserted mid-operation: every register, counter and the output latch return to reset values on the next edge. `port_io` goes high-Z and `irq` goes to 0 in that cycle.

## Timing
- Register write takes effect at the `sys_clk` edge with `ce` & `wr`. The pin drive reflects a new `DATA`/`EN`/`CFG` combinationally after that edge, i.e. 0-cycle pin latency.
- Read is combinational in the same cycle. `DATA` reflects the state as of the last edge.
- Input latency with `DEB_DIV` = 0, counting from the first edge that samples the new pin level:
  - 2 cycles of synchronizer, then 3 ticks to fill the history.
  - The debounced value changes on edge 5.
  - `IRQ_ST` sets on edge 6, and `irq` rises in the same cycle.
- For a general `DEB_DIV` = N, latency is at most 2 + 3(N+1) + 1 cycles.
- Glitch rejection: a pulse shorter than 3 consecutive ticks never changes the debounced value.
- No handshake. The bus cycle is single-cycle with no wait states.

## Test plan
- **Reset:** assert `rst_sync` for 3 cycles, then read all registers. Expected: `DATA` = 0, `CFG` = FFFFFFFF, `EN` = 0, `IRQ_EN` = 0, `IRQ_ST` = 0, `DEB_DIV` = 0, `port_io` all Z, `irq` = 0.
- **Output drive:** write `EN` = FFFFFFF0, `CFG` = 0000000F, `DATA` = A5A5A5A0. Expected: `port_io[31:4]` = A5A5A5A, `port_io[3:0]` = Z, and a read of `DATA` returns A5A5A5A0 with the input bits at 0.
- **Button press:** with `EN[3:0]` = F, `IRQ_EN` = 8 and `DEB_DIV` = 0, drive `port_io[3]` = 1 for 5 cycles (100 ns at 20 ns period). Expected: `IRQ_ST` = 8 and `irq` = 1 on the 6th edge after the first sample. Then write `IRQ_ST` = 8; expected `IRQ_ST` = 0 and `irq` = 0.
- **Glitch reject:** with `DEB_DIV` = 3, drive a 10-cycle pulse on `port_io[2]`. Expected: `DATA[2]` stays 0 and `IRQ_ST` stays 0.
- **Masking:** with `IRQ_EN` = 0, press bits 1 and 0 sequentially. Expected: `IRQ_ST` = 3 and `irq` = 0. Then write `IRQ_EN` = 1; expected `irq` = 1 in the same cycle.
- **Set/clear collision and reset mid-run:** write `IRQ_ST` = 1 on the exact edge where `rise[0]` occurs. Expected: `IRQ_ST[0]` = 1. Then assert `rst_sync` during output drive; expected all pins Z and `irq` = 0 on the next edge.
